// File: rtl/single_loop_if.sv
// Handshake bundle between the ControlUnit loop stack and one loop iteration counter.
// The master drives the loop configuration and jump events; the slave reports progress.
interface single_loop_if #(
  parameter int BITS = 18
);
  logic            should_increment;
  logic [BITS-1:0] initial_iteration_count;
  logic            initial_is_inner_independent_loop;
  logic            jumped;
  logic            done;
  logic [BITS-1:0] current_iteration;

  modport master (
    output should_increment,
    output initial_iteration_count,
    output initial_is_inner_independent_loop,
    output jumped,
    input  done,
    input  current_iteration
  );

  modport slave (
    input  should_increment,
    input  initial_iteration_count,
    input  initial_is_inner_independent_loop,
    input  jumped,
    output done,
    output current_iteration
  );
endinterface

// File: rtl/single_loop.sv
// Per-loop iteration counter: loads a trip count while reset is high, counts
// end-of-loop back-jumps, and flags the last iteration with a sticky done.
module single_loop #(
  parameter int BITS                  = 18,
  parameter int SUPERSCALAR_LOG_WIDTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  single_loop_if.slave bus
);
  localparam int W = 1 << SUPERSCALAR_LOG_WIDTH;

  logic [BITS-1:0] limit_q;
  logic            indep_q;
  logic [BITS-1:0] iter_q;
  logic            done_q;

  logic [BITS:0]   rounded_count;
  logic [BITS:0]   ceil_count;
  logic [BITS-1:0] limit_load;
  logic            inc;
  logic [BITS-1:0] iter_next;
  logic            done_next;

  // One extra bit so count + W-1 cannot wrap before the divide.
  assign rounded_count = {1'b0, bus.initial_iteration_count} + (BITS+1)'(W - 1);
  assign ceil_count    = rounded_count >> SUPERSCALAR_LOG_WIDTH;
  assign limit_load    = bus.initial_is_inner_independent_loop
                         ? ceil_count[BITS-1:0]
                         : bus.initial_iteration_count;

  assign inc       = bus.jumped & bus.should_increment & ~done_q;
  assign iter_next = iter_q + BITS'(inc);
  assign done_next = (limit_q <= BITS'(1)) | (iter_next >= limit_q - BITS'(1));

  // NOTE: the configuration registers are loaded synchronously while reset is
  // high, so they carry no asynchronous reset; a data-dependent value in an
  // async reset branch would become an asynchronous load.
  always_ff @(posedge clk) begin
    if (reset) begin
      limit_q <= limit_load;
      indep_q <= bus.initial_is_inner_independent_loop;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iter_q <= '0;
      done_q <= 1'b0;
    end else begin
      iter_q <= iter_next;
      done_q <= done_next;
    end
  end

  // Once done is set, inc is blocked, so iter saturates at limit-1.
  assign bus.done              = done_q;
  assign bus.current_iteration = indep_q ? (iter_q << SUPERSCALAR_LOG_WIDTH) : iter_q;

endmodule

// File: tb/tb_single_loop.sv
// Directed, table-driven bench for single_loop plus a hand-written re-arm
// sequence that checks the asynchronous clear between clock edges.
module tb_single_loop;
  localparam int BITS = 18;

  logic clk;
  logic reset;

  single_loop_if #(.BITS(BITS)) bus ();

  single_loop #(
    .BITS                  (BITS),
    .SUPERSCALAR_LOG_WIDTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            rst;
    logic [BITS-1:0] count;
    logic            indep;
    logic            si;
    logic            jmp;
    logic            exp_done;
    logic [BITS-1:0] exp_cur;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic rst, input logic [BITS-1:0] count,
                     input logic indep, input logic si, input logic jmp,
                     input logic exp_done, input logic [BITS-1:0] exp_cur);
    vec_t v;
    v.name = name; v.rst = rst; v.count = count; v.indep = indep;
    v.si = si; v.jmp = jmp; v.exp_done = exp_done; v.exp_cur = exp_cur;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic [BITS-1:0] count, input logic indep,
                       input logic si, input logic jmp);
    reset                                 = rst;
    bus.initial_iteration_count           = count;
    bus.initial_is_inner_independent_loop = indep;
    bus.should_increment                  = si;
    bus.jumped                            = jmp;
  endtask

  initial begin
    drive(1'b1, 18'd3, 1'b0, 1'b0, 1'b0);

    // Plain loop, count=3: jumps after 3-clock windows, cur 0,1,2.
    add("plain_rst",   1, 18'd3, 0, 1, 1, 0, 18'd0);
    add("plain_w0a",   0, 18'd3, 0, 1, 0, 0, 18'd0);
    add("plain_w0b",   0, 18'd3, 0, 1, 0, 0, 18'd0);
    add("plain_w0c",   0, 18'd3, 0, 1, 0, 0, 18'd0);
    add("plain_j1",    0, 18'd3, 0, 1, 1, 0, 18'd1);
    add("plain_w1a",   0, 18'd3, 0, 1, 0, 0, 18'd1);
    add("plain_w1b",   0, 18'd3, 0, 1, 0, 0, 18'd1);
    add("plain_j2",    0, 18'd3, 0, 1, 1, 1, 18'd2);
    add("plain_idl1",  0, 18'd3, 0, 1, 0, 1, 18'd2);
    add("plain_idl2",  0, 18'd3, 0, 1, 0, 1, 18'd2);

    // Independent loop, count=12 -> limit 3, cur 0,4,8.
    add("indep_rst",   1, 18'd12, 1, 1, 1, 0, 18'd0);
    add("indep_w0a",   0, 18'd12, 1, 1, 0, 0, 18'd0);
    add("indep_w0b",   0, 18'd12, 1, 1, 0, 0, 18'd0);
    add("indep_w0c",   0, 18'd12, 1, 1, 0, 0, 18'd0);
    add("indep_j1",    0, 18'd12, 1, 1, 1, 0, 18'd4);
    add("indep_w1a",   0, 18'd12, 1, 1, 0, 0, 18'd4);
    add("indep_w1b",   0, 18'd12, 1, 1, 0, 0, 18'd4);
    add("indep_j2",    0, 18'd12, 1, 1, 1, 1, 18'd8);
    add("indep_idl",   0, 18'd12, 1, 1, 0, 1, 18'd8);

    // Saturation: five back-to-back jumps on count=3.
    add("sat_rst",     1, 18'd3, 0, 1, 0, 0, 18'd0);
    add("sat_j1",      0, 18'd3, 0, 1, 1, 0, 18'd1);
    add("sat_j2",      0, 18'd3, 0, 1, 1, 1, 18'd2);
    add("sat_j3",      0, 18'd3, 0, 1, 1, 1, 18'd2);
    add("sat_j4",      0, 18'd3, 0, 1, 1, 1, 18'd2);
    add("sat_j5",      0, 18'd3, 0, 1, 1, 1, 18'd2);

    // Hold: jumped without should_increment does not count.
    add("hold_rst",    1, 18'd3, 0, 0, 1, 0, 18'd0);
    add("hold_c1",     0, 18'd3, 0, 0, 1, 0, 18'd0);
    add("hold_c2",     0, 18'd3, 0, 0, 1, 0, 18'd0);
    add("hold_c3",     0, 18'd3, 0, 0, 1, 0, 18'd0);
    add("hold_c4",     0, 18'd3, 0, 0, 1, 0, 18'd0);
    add("hold_rel",    0, 18'd3, 0, 1, 1, 0, 18'd1);

    // Single-iteration loops: limit 1 and limit 0.
    add("cnt1_rst",    1, 18'd1, 0, 1, 0, 0, 18'd0);
    add("cnt1_idl",    0, 18'd1, 0, 1, 0, 1, 18'd0);
    add("cnt1_jmp",    0, 18'd1, 0, 1, 1, 1, 18'd0);
    add("cnt0_rst",    1, 18'd0, 0, 1, 0, 0, 18'd0);
    add("cnt0_idl",    0, 18'd0, 0, 1, 0, 1, 18'd0);

    // Max count, indep: ceil needs the extra bit -> limit 65536.
    add("big_rst",     1, 18'h3FFFF, 1, 1, 0, 0, 18'd0);
    add("big_idl",     0, 18'h3FFFF, 1, 1, 0, 0, 18'd0);
    add("big_j1",      0, 18'h3FFFF, 1, 1, 1, 0, 18'd4);

    // count=5, indep -> limit 2; done after one jump, cur 0,4.
    add("cnt5_rst",    1, 18'd5, 1, 1, 0, 0, 18'd0);
    add("cnt5_idl",    0, 18'd5, 1, 1, 0, 0, 18'd0);
    add("cnt5_j1",     0, 18'd5, 1, 1, 1, 1, 18'd4);
    add("cnt5_j2",     0, 18'd5, 1, 1, 1, 1, 18'd4);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].count, vecs[i].indep, vecs[i].si, vecs[i].jmp);
      @(posedge clk);
      #1;
      check({vecs[i].name, ".done"}, 32'(bus.done), 32'(vecs[i].exp_done));
      check({vecs[i].name, ".cur"},  32'(bus.current_iteration), 32'(vecs[i].exp_cur));
    end

    // Re-arm from done=1 (cnt5 left cur=4): async clear between edges.
    drive(1'b1, 18'd3, 1'b0, 1'b0, 1'b1);
    #1;
    check("rearm.async_done", 32'(bus.done), 32'd0);
    check("rearm.async_cur",  32'(bus.current_iteration), 32'd0);
    @(posedge clk);
    #1;
    check("rearm.rst_edge_done", 32'(bus.done), 32'd0);
    drive(1'b0, 18'd3, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("rearm.post1_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    check("rearm.post2_done", 32'(bus.done), 32'd0);
    check("rearm.post2_cur",  32'(bus.current_iteration), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
